alu_seq: RTL and testbench

//   Parametrised, multi-cycle successor of the snake-core 8-bit ALU. It has the

---
 rtl/alu_seq.sv | 202 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: parametrised multi-cycle ALU with strobe-latched operands, a serial
// rotate and a shift-add multiplier behind a busy/done handshake.
module alu_seq #(
    parameter int unsigned W      = 8,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   opcode,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         c_ain,
    input  logic         c_bin,
    input  logic         c_alu,
    input  logic         c_aout,
    output logic [W-1:0] a_out,
    output logic         flag,
    output logic         busy,
    output logic         done
);

    localparam int unsigned HALF = W / 2;
    localparam int unsigned KW   = $clog2(W);
    localparam int unsigned CW   = KW + 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_ROW  = 3'd3;
    localparam logic [2:0] OP_COL  = 3'd4;
    localparam logic [2:0] OP_INCL = 3'd5;
    localparam logic [2:0] OP_F    = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_MUL  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   work_q, work_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           flag_q, flag_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [W:0]     add_sum;
    logic [W:0]     addi_sum;
    logic [W-1:0]   rot_next;
    logic [2*W-1:0] prod_next;
    logic [KW-1:0]  rot_k;

    assign add_sum   = {1'b0, a_q} + {1'b0, b_q};
    assign addi_sum  = {1'b0, a_q} + (W+1)'(b_q[HALF-1:0]);
    assign rot_next  = {work_q[W-2:0], work_q[W-1]};
    assign prod_next = prod_q + (work_q[0] ? mcand_q : '0);
    assign rot_k     = b_q[KW-1:0];

    assign a_out = c_aout ? acc_q : '0;
    assign flag  = flag_q;
    assign busy  = busy_q;
    assign done  = done_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            work_q  <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            work_q  <= work_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, operand latching and op execution
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        work_d  = work_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        done_d  = 1'b0;

        if (state_q == ST_IDLE) begin
            if (c_ain) a_d = a_in;
            if (c_bin) b_d = b_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (c_alu) begin
                    done_d = 1'b1;
                    case (opcode)
                        OP_ADD: begin
                            acc_d  = add_sum[W-1:0];
                            flag_d = add_sum[W];
                        end
                        OP_SUB: begin
                            acc_d  = a_q - b_q;
                            flag_d = (a_q < b_q);
                        end
                        OP_ADDI: begin
                            acc_d  = addi_sum[W-1:0];
                            flag_d = addi_sum[W];
                        end
                        OP_ROW: begin
                            acc_d  = W'(b_q[W-1:HALF]);
                            flag_d = (b_q[W-1:HALF] == '0);
                        end
                        OP_COL: begin
                            acc_d  = W'(b_q[HALF-1:0]);
                            flag_d = (b_q[HALF-1:0] == '0);
                        end
                        OP_INCL: begin
                            if (rot_k == '0) begin
                                acc_d  = a_q;
                                flag_d = 1'b0;
                            end else begin
                                done_d  = 1'b0;
                                state_d = ST_ROT;
                                work_d  = a_q;
                                cnt_d   = CW'(rot_k);
                            end
                        end
                        OP_F: begin
                            flag_d = (a_q == b_q);
                        end
                        OP_MUL: begin
                            if (MUL_EN) begin
                                done_d  = 1'b0;
                                state_d = ST_MUL;
                                work_d  = b_q;
                                mcand_d = (2*W)'(a_q);
                                prod_d  = '0;
                                cnt_d   = CW'(W);
                            end else begin
                                flag_d = 1'b0;
                            end
                        end
                    endcase
                end
            end
            ST_ROT: begin
                work_d = rot_next;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    acc_d   = rot_next;
                    flag_d  = work_q[W-1];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                // Multiplier consumed LSB first; multiplicand shifts up each step
                prod_d  = prod_next;
                mcand_d = mcand_q << 1;
                work_d  = work_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    acc_d   = prod_next[W-1:0];
                    flag_d  = |prod_next[2*W-1:W];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq: stimulus pushes expected results,
// a monitor pops them on every done pulse.
module tb_alu_seq;

    localparam int W = 8;
    localparam int H = W / 2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_ROW  = 3'd3;
    localparam logic [2:0] OP_COL  = 3'd4;
    localparam logic [2:0] OP_INCL = 3'd5;
    localparam logic [2:0] OP_F    = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   opcode;
    logic [W-1:0] a_in, b_in;
    logic         c_ain, c_bin, c_alu, c_aout;
    logic [W-1:0] a_out;
    logic         flag, busy, done;

    always #5 clk = ~clk;

    alu_seq #(.W(W), .MUL_EN(1'b1)) dut (
        .clk    (clk),
        .reset  (reset),
        .opcode (opcode),
        .a_in   (a_in),
        .b_in   (b_in),
        .c_ain  (c_ain),
        .c_bin  (c_bin),
        .c_alu  (c_alu),
        .c_aout (c_aout),
        .a_out  (a_out),
        .flag   (flag),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        logic [W-1:0] acc;
        logic         flg;
    } exp_t;

    exp_t         sb_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] ma, mb, macc;
    logic         mflag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: op result from the arithmetic definition of each opcode
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [W-1:0] acc,
                                  output logic [W-1:0] r, output logic f, output int cyc);
        int unsigned      ai = a;
        int unsigned      bi = b;
        int unsigned      s, k;
        longint unsigned  p;
        cyc = 0;
        r   = acc;
        f   = 1'b0;
        case (op)
            OP_ADD:  begin s = ai + bi; r = W'(s); f = (s >= (1 << W)); end
            OP_SUB:  begin r = W'(ai - bi); f = (ai < bi); end
            OP_ADDI: begin s = ai + (bi % (1 << H)); r = W'(s); f = (s >= (1 << W)); end
            OP_ROW:  begin r = W'(bi >> H); f = (r == '0); end
            OP_COL:  begin r = W'(bi % (1 << H)); f = (r == '0); end
            OP_INCL: begin
                k = bi % W;
                if (k == 0) begin
                    r = a;
                    f = 1'b0;
                end else begin
                    r   = W'((ai << k) | (ai >> (W - k)));
                    f   = a[W - k];
                    cyc = int'(k);
                end
            end
            OP_F:    begin f = (a == b); end
            default: begin
                p   = longint'(ai) * longint'(bi);
                r   = W'(p);
                f   = (p >= (1 << W));
                cyc = W;
            end
        endcase
    endfunction

    // Monitor: every done pulse consumes one expected result
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected actual=1 required=0 at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("acc", 32'(a_out), 32'(e.acc));
                    check("flag", 32'(flag), 32'(e.flg));
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input bit go, input bit la, input bit lb,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit jam);
        logic [W-1:0] r;
        logic         f;
        int           ecyc, cyc;
        ecyc = 0;
        @(negedge clk);
        opcode = op; a_in = a; b_in = b;
        c_ain = la; c_bin = lb; c_alu = go;
        if (go) begin
            model(op, ma, mb, macc, r, f, ecyc);
            sb_q.push_back('{r, f});
            macc  = r;
            mflag = f;
        end
        if (la) ma = a;
        if (lb) mb = b;
        @(posedge clk); #1;
        c_ain = 1'b0; c_bin = 1'b0; c_alu = 1'b0;
        if (go) begin
            cyc = 0;
            while (busy === 1'b1 && cyc < 4 * W) begin
                // Mid-op strobes must be ignored entirely
                if (jam && ecyc >= 3 && cyc == 1) begin
                    c_alu = 1'b1; c_ain = 1'b1; c_bin = 1'b1;
                    a_in = ~ma; b_in = ~mb; opcode = OP_ADD;
                end else if (jam && ecyc >= 3 && cyc == 2) begin
                    c_alu = 1'b0; c_ain = 1'b0; c_bin = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
            end
            check("busy_cycles", 32'(cyc), 32'(ecyc));
        end
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        issue(OP_ADD, 1'b0, 1'b1, 1'b1, a, b, 1'b0);
    endtask

    task automatic run(input logic [2:0] op);
        issue(op, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; opcode = '0; a_in = '0; b_in = '0;
        c_ain = 1'b0; c_bin = 1'b0; c_alu = 1'b0; c_aout = 1'b1;
        ma = '0; mb = '0; macc = '0; mflag = 1'b0;
        #1;
        check("rst_a_out", 32'(a_out), 32'd0);
        check("rst_flag", 32'(flag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        load(8'd5, 8'd3);     run(OP_ADD);
        load(8'd200, 8'd100); run(OP_ADD);
        load(8'd4, 8'd9);     run(OP_SUB);
        load(8'd9, 8'd4);     run(OP_SUB);
        load(8'd7, 8'd7);     run(OP_F);
        load(8'd2, 8'hAB);    run(OP_ROW); run(OP_COL);
        load(8'd2, 8'h17);    run(OP_ADDI);

        @(negedge clk); c_aout = 1'b0;
        @(posedge clk); #1;
        check("aout_gated", 32'(a_out), 32'd0);
        @(negedge clk); c_aout = 1'b1;
        @(posedge clk); #1;
        check("aout_open", 32'(a_out), 32'(macc));

        load(8'h81, 8'd3);
        issue(OP_INCL, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        run(OP_F);
        load(8'd13, 8'd11); run(OP_MUL);
        load(8'd20, 8'd20); run(OP_MUL);

        // Reset during MUL cycle 4 aborts the op
        load(8'd13, 8'd11);
        @(negedge clk);
        opcode = OP_MUL; c_alu = 1'b1;
        @(posedge clk); #1;
        c_alu = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mul_busy_mid", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_a_out", 32'(a_out), 32'd0);
        check("abort_flag", 32'(flag), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        ma = '0; mb = '0; macc = '0; mflag = 1'b0;
        @(negedge clk); reset = 1'b1;
        run(OP_ADD);
        load(8'd5, 8'd3); run(OP_ADD);

        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
